mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width; byte-enable width is DATA_W/8.
REQ-003 SHALL have port i_clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port i_rst  in  1  synchronous reset, active-high.
REQ-005 SHALL have ports i_if_req in 1, i_if_addr in ADDR_W, i_if_flush in 1  fetch request, address, and drop-pending-fetch.
REQ-006 SHALL have ports o_if_gnt out 1, o_if_rvalid out 1, o_if_rdata out DATA_W, o_if_stall out 1  fetch grant pulse, response pulse, data, stall to hazard unit.
REQ-007 SHALL have ports i_dm_req in 1, i_dm_we in 1, i_dm_addr in ADDR_W, i_dm_wdata in DATA_W, i_dm_be in DATA_W/8  data-side request.
REQ-008 SHALL have ports o_dm_gnt out 1, o_dm_rvalid out 1, o_dm_rdata out DATA_W, o_dm_stall out 1  data-side grant, response, data, stall.
REQ-009 SHALL have ports o_mem_req, o_mem_we out 1, o_mem_addr out ADDR_W, o_mem_wdata out DATA_W, o_mem_be out DATA_W/8  shared memory request.
REQ-010 SHALL have ports i_mem_gnt in 1, i_mem_rvalid in 1, i_mem_rdata in DATA_W  memory accept, response, read data (writes also return one rvalid).

Function
REQ-011 SHALL implement FSM IDLE, WAIT_GNT, WAIT_RSP, with at most one outstanding memory transaction.
REQ-012 IDLE: on any request, SHALL select owner, latch owner's addr/we/wdata/be into registers, pulse owner's gnt for one cycle, go to WAIT_GNT.
REQ-013 Fixed priority (macro absent): data side SHALL win when both request in the same IDLE cycle.
REQ-014 o_mem_* SHALL be driven only from the latched registers; o_mem_req SHALL be 1 exactly in WAIT_GNT (one-cycle latency from request to o_mem_req).
REQ-015 WAIT_GNT: i_mem_gnt=1 SHALL move to WAIT_RSP; with i_mem_gnt=1 and i_mem_rvalid=1 in the same cycle SHALL complete and move to IDLE.
REQ-016 WAIT_RSP: i_mem_rvalid=1 SHALL route i_mem_rdata to owner's rdata, pulse owner's rvalid combinationally in that cycle, go to IDLE.
REQ-017 Fetch writes: fetch owner SHALL always present o_mem_we=0 and o_mem_be all-ones.
REQ-018 i_if_flush while owner is fetch in WAIT_GNT/WAIT_RSP SHALL set a discard flag; that response SHALL complete the FSM but suppress o_if_rvalid; flag cleared on return to IDLE.
REQ-019 i_if_flush in IDLE or when owner is data SHALL have no effect.
REQ-020 o_if_stall SHALL equal i_if_req AND NOT o_if_rvalid; o_dm_stall SHALL equal i_dm_req AND NOT o_dm_rvalid.
REQ-021 i_mem_rvalid or i_mem_gnt in IDLE SHALL be ignored (no rvalid pulse, no state change).
REQ-022 Requesters hold req/addr stable until their rvalid; arbitration SHALL occur only in IDLE, so a completing cycle never re-grants (next grant earliest one cycle after completion).
REQ-023 o_if_rdata/o_dm_rdata SHALL be 0 when the respective rvalid is 0.

Reset
REQ-024 i_rst SHALL force IDLE, clear owner, discard flag, latched registers and round-robin pointer; all outputs 0 in the cycle after reset (stall outputs follow REQ-020).
REQ-025 Reset mid-transaction SHALL abandon it; a later i_mem_rvalid SHALL be ignored per REQ-021.

Configuration
REQ-026 Macro MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests SHALL grant the side not granted last (pointer reset to favour data); undefined: fixed data priority per REQ-013, no pointer register.

Structure
REQ-027 Shared package SHALL hold the FSM state enum, owner enum (OWN_IF, OWN_DM), and default ADDR_W/DATA_W constants.
REQ-028 One sub-module mem_arb_pick SHALL contain the grant-selection logic (fixed or round-robin).

Verification
REQ-029 Fetch alone addr 0x100, gnt next cycle, rvalid 2 cycles later rdata 0x00A00093 -> o_if_rvalid one pulse with 0x00A00093, o_mem_we=0, be=0xF.
REQ-030 Both request same cycle (if 0x104, dm read 0x2000) -> o_dm_gnt first, o_mem_addr=0x2000; fetch granted one cycle after dm rvalid; with macro, second simultaneous pair grants fetch first.
REQ-031 Data write 0x2004 data 0xDEADBEEF be=0x3, gnt and rvalid same cycle -> single o_mem_req cycle, o_dm_rvalid pulse, FSM IDLE next.
REQ-032 Fetch 0x108 pending, i_if_flush in WAIT_RSP -> response absorbed, o_if_rvalid stays 0, FSM returns IDLE.
REQ-033 i_rst asserted in WAIT_RSP, then i_mem_rvalid=1 -> no rvalid on either side, all outputs 0.
REQ-034 Spurious i_mem_rvalid in IDLE -> no output change; stall outputs track requests per REQ-020 throughout.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Brief    : Shared types and default widths for the fetch/data memory-port
//            arbiter: FSM state encoding, owner encoding and the default
//            address and data widths.
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    localparam int c_default_addr_w = 32;
    localparam int c_default_data_w = 32;

    // Arbiter sequencing: one memory transaction in flight at most
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_GNT = 2'd1,
        ST_WAIT_RSP = 2'd2
    } arb_state_t;

    // Which requester owns the transaction currently in flight
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pick
// Brief    : Grant selection between the fetch and data requesters.
//            Default build: data side always wins a simultaneous request.
//            With MEM_ARB_ROUND_ROBIN_EN defined: a contested request goes to
//            the side that lost the previous contested request; the pointer
//            comes out of reset favouring the data side.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_contend,     // both sides requesting while arbiter is idle
`endif
    input  logic i_if_req,
    input  logic i_dm_req,
    output logic o_pick_dm      // 1: data side selected, 0: fetch side
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Winner of the last contested arbitration
    owner_t r_last;

    // Remember who won each contested grant so the other side wins next time
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last <= OWN_IF;
        end else if (i_contend) begin
            r_last <= o_pick_dm ? OWN_DM : OWN_IF;
        end
    end

    // Contested: alternate; otherwise whichever side is asking
    always_comb begin
        o_pick_dm = i_dm_req || !i_if_req;
        if (i_if_req && i_dm_req) begin
            o_pick_dm = (r_last == OWN_IF);
        end
    end
`else
    // Data side unless only the fetch side is asking
    assign o_pick_dm = i_dm_req || !i_if_req;
`endif

endmodule : mem_arb_pick
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory request/response port between an instruction
//            fetch requester and a data requester. One transaction in flight;
//            the owner's request fields are latched at grant and drive the
//            memory port for the whole transaction. A fetch may be flushed
//            while in flight: its response is absorbed and not forwarded.
//            Optional macro: MEM_ARB_ROUND_ROBIN_EN (alternate contested
//            grants instead of fixed data priority).
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = c_default_addr_w,
    parameter int DATA_W = c_default_data_w
) (
    input  logic                i_clk,
    input  logic                i_rst,
    // fetch side
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    input  logic                i_if_flush,
    output logic                o_if_gnt,
    output logic                o_if_rvalid,
    output logic [DATA_W-1:0]   o_if_rdata,
    output logic                o_if_stall,
    // data side
    input  logic                i_dm_req,
    input  logic                i_dm_we,
    input  logic [ADDR_W-1:0]   i_dm_addr,
    input  logic [DATA_W-1:0]   i_dm_wdata,
    input  logic [DATA_W/8-1:0] i_dm_be,
    output logic                o_dm_gnt,
    output logic                o_dm_rvalid,
    output logic [DATA_W-1:0]   o_dm_rdata,
    output logic                o_dm_stall,
    // shared memory port
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_be,
    input  logic                i_mem_gnt,
    input  logic                i_mem_rvalid,
    input  logic [DATA_W-1:0]   i_mem_rdata
);

    localparam int c_be_w = DATA_W / 8;

    arb_state_t          r_state;
    owner_t              r_owner;
    logic                r_discard;     // in-flight fetch was flushed
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_be_w-1:0]   r_be;

    logic w_idle;
    logic w_any_req;
    logic w_take;
    logic w_pick_dm;
    logic w_complete;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_any_req = i_if_req || i_dm_req;
    assign w_take    = w_idle && w_any_req;

    // Response that ends the transaction: either folded into the accept
    // cycle or arriving later while waiting for it. Responses seen in IDLE
    // are stray and never count.
    assign w_complete = ((r_state == ST_WAIT_GNT) && i_mem_gnt && i_mem_rvalid) ||
                        ((r_state == ST_WAIT_RSP) && i_mem_rvalid);

    mem_arb_pick u_pick (
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_contend (w_idle && i_if_req && i_dm_req),
`endif
        .i_if_req  (i_if_req),
        .i_dm_req  (i_dm_req),
        .o_pick_dm (w_pick_dm)
    );

    // Grant pulses are issued in the IDLE cycle that accepts the request
    assign o_if_gnt = w_take && !w_pick_dm;
    assign o_dm_gnt = w_take &&  w_pick_dm;

    // Response routing to the owner; a flushed fetch swallows its response
    assign o_if_rvalid = w_complete && (r_owner == OWN_IF) && !r_discard;
    assign o_dm_rvalid = w_complete && (r_owner == OWN_DM);
    assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
    assign o_dm_rdata  = o_dm_rvalid ? i_mem_rdata : '0;

    assign o_if_stall = i_if_req && !o_if_rvalid;
    assign o_dm_stall = i_dm_req && !o_dm_rvalid;

    // Memory port comes only from the latched request
    assign o_mem_req   = (r_state == ST_WAIT_GNT);
    assign o_mem_we    = r_we;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_mem_be    = r_be;

    // Transaction sequencer: accept, wait for memory accept, wait for response
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_owner   <= OWN_IF;
            r_discard <= 1'b0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_be      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state <= ST_WAIT_GNT;
                        if (w_pick_dm) begin
                            r_owner <= OWN_DM;
                            r_addr  <= i_dm_addr;
                            r_we    <= i_dm_we;
                            r_wdata <= i_dm_wdata;
                            r_be    <= i_dm_be;
                        end else begin
                            // Fetches are always full-width reads
                            r_owner <= OWN_IF;
                            r_addr  <= i_if_addr;
                            r_we    <= 1'b0;
                            r_wdata <= '0;
                            r_be    <= '1;
                        end
                    end
                end
                ST_WAIT_GNT: begin
                    if (i_mem_gnt) begin
                        r_state <= i_mem_rvalid ? ST_IDLE : ST_WAIT_RSP;
                    end
                end
                ST_WAIT_RSP: begin
                    if (i_mem_rvalid) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Flush only matters for a fetch that is actually in flight
            if (w_complete) begin
                r_discard <= 1'b0;
            end else if (!w_idle && (r_owner == OWN_IF) && i_if_flush) begin
                r_discard <= 1'b1;
            end
        end
    end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench for mem_port_arbiter. A transaction-level
//            model (pending requests, arbitration rule, memory latency
//            choices) predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int c_free = 0;
    localparam int c_req  = 1;
    localparam int c_rsp  = 2;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_if_req, i_if_flush;
    logic [31:0] i_if_addr;
    logic        o_if_gnt, o_if_rvalid, o_if_stall;
    logic [31:0] o_if_rdata;
    logic        i_dm_req, i_dm_we;
    logic [31:0] i_dm_addr, i_dm_wdata;
    logic [3:0]  i_dm_be;
    logic        o_dm_gnt, o_dm_rvalid, o_dm_stall;
    logic [31:0] o_dm_rdata;
    logic        o_mem_req, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        i_mem_gnt, i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
        .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
        .o_if_stall(o_if_stall),
        .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr),
        .i_dm_wdata(i_dm_wdata), .i_dm_be(i_dm_be),
        .o_dm_gnt(o_dm_gnt), .o_dm_rvalid(o_dm_rvalid), .o_dm_rdata(o_dm_rdata),
        .o_dm_stall(o_dm_stall),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
        .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Model: requesters, in-flight transaction, memory latency plan
    int          phase;
    bit          own_dm, discard;
    int          gwait, rwait;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    bit          rr_last_dm;
`endif
    bit          if_pend, dm_pend, dm_we_m;
    logic [31:0] if_a, dm_a, dm_wd;
    logic [3:0]  dm_b;
    logic [31:0] g_addr, g_wdata;
    logic        g_we;
    logic [3:0]  g_be;

    // Scenario controls
    bit          rand_en, force_flush, force_spur, rd_force;
    int          force_gw, force_rw;
    logic [31:0] rd_val;

    // Observations
    int          cyc, cnt_if_rv, cnt_dm_rv, cnt_mem_req, first_gnt, t_dm_rv, t_if_gnt;
    logic [31:0] last_if_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        cnt_if_rv = 0; cnt_dm_rv = 0; cnt_mem_req = 0;
        first_gnt = -1; t_dm_rv = -100; t_if_gnt = -100;
        last_if_rdata = '0;
    endtask

    task automatic model_reset();
        phase = c_free; own_dm = 1'b0; discard = 1'b0; gwait = 0; rwait = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr_last_dm = 1'b0;
`endif
        if_pend = 1'b0; dm_pend = 1'b0;
    endtask

    // Called at posedge+1: expects every output to be zero
    task automatic check_all_zero(input string p);
        #1;
        chk({p, "_if_gnt"},    64'(o_if_gnt),    64'd0);
        chk({p, "_if_rvalid"}, 64'(o_if_rvalid), 64'd0);
        chk({p, "_if_rdata"},  64'(o_if_rdata),  64'd0);
        chk({p, "_if_stall"},  64'(o_if_stall),  64'd0);
        chk({p, "_dm_gnt"},    64'(o_dm_gnt),    64'd0);
        chk({p, "_dm_rvalid"}, 64'(o_dm_rvalid), 64'd0);
        chk({p, "_dm_rdata"},  64'(o_dm_rdata),  64'd0);
        chk({p, "_dm_stall"},  64'(o_dm_stall),  64'd0);
        chk({p, "_mem_req"},   64'(o_mem_req),   64'd0);
        chk({p, "_mem_we"},    64'(o_mem_we),    64'd0);
        chk({p, "_mem_addr"},  64'(o_mem_addr),  64'd0);
        chk({p, "_mem_wdata"}, 64'(o_mem_wdata), 64'd0);
        chk({p, "_mem_be"},    64'(o_mem_be),    64'd0);
    endtask

    // One clock of stimulus + prediction + comparison; entered at posedge+1
    task automatic cycle();
        bit mg, mr, fl, comp, real_fl, any, win_dm, e_if_rv, e_dm_rv;
        logic [31:0] rd;
        mg = 1'b0; mr = 1'b0; fl = 1'b0; real_fl = 1'b0;
        rd = rd_force ? rd_val : $urandom;
        if (phase == c_req && gwait == 0) begin
            mg = 1'b1;
            mr = (rwait == 0);
        end
        if (phase == c_rsp && rwait == 0) mr = 1'b1;
        comp = mr;
        // stray memory handshakes while nothing is in flight
        if (phase == c_free && (force_spur || (rand_en && $urandom_range(3) == 0))) begin
            mg = force_spur || ($urandom_range(1) == 1);
            mr = 1'b1;
        end
        if (phase != c_free && !own_dm) begin
            if (!discard && !comp &&
                (force_flush ? (phase == c_rsp) : (rand_en && $urandom_range(5) == 0))) begin
                fl = 1'b1;
                real_fl = 1'b1;
            end
        end else if (rand_en && $urandom_range(7) == 0) begin
            fl = 1'b1;      // flush with no fetch in flight: no effect
        end

        any = if_pend || dm_pend;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        win_dm = (if_pend && dm_pend) ? !rr_last_dm : dm_pend;
`else
        win_dm = dm_pend;
`endif

        i_if_req = if_pend; i_if_addr = if_a; i_if_flush = fl;
        i_dm_req = dm_pend; i_dm_we = dm_we_m; i_dm_addr = dm_a;
        i_dm_wdata = dm_wd; i_dm_be = dm_b;
        i_mem_gnt = mg; i_mem_rvalid = mr; i_mem_rdata = rd;
        #1;

        e_if_rv = comp && !own_dm && !discard;
        e_dm_rv = comp && own_dm;
        chk("if_gnt",    64'(o_if_gnt),    64'(phase == c_free && any && !win_dm));
        chk("dm_gnt",    64'(o_dm_gnt),    64'(phase == c_free && any && win_dm));
        chk("mem_req",   64'(o_mem_req),   64'(phase == c_req));
        if (phase == c_req) begin
            chk("mem_addr", 64'(o_mem_addr), 64'(g_addr));
            chk("mem_we",   64'(o_mem_we),   64'(g_we));
            chk("mem_be",   64'(o_mem_be),   64'(g_be));
            if (own_dm) chk("mem_wdata", 64'(o_mem_wdata), 64'(g_wdata));
        end
        chk("if_rvalid", 64'(o_if_rvalid), 64'(e_if_rv));
        chk("dm_rvalid", 64'(o_dm_rvalid), 64'(e_dm_rv));
        chk("if_rdata",  64'(o_if_rdata),  64'(e_if_rv ? rd : 32'd0));
        chk("dm_rdata",  64'(o_dm_rdata),  64'(e_dm_rv ? rd : 32'd0));
        chk("if_stall",  64'(o_if_stall),  64'(if_pend && !e_if_rv));
        chk("dm_stall",  64'(o_dm_stall),  64'(dm_pend && !e_dm_rv));

        if (o_if_rvalid) begin cnt_if_rv++; last_if_rdata = o_if_rdata; end
        if (o_dm_rvalid) begin cnt_dm_rv++; t_dm_rv = cyc; end
        if (o_mem_req) cnt_mem_req++;
        if (o_if_gnt) begin t_if_gnt = cyc; if (first_gnt < 0) first_gnt = 0; end
        if (o_dm_gnt && first_gnt < 0) first_gnt = 1;

        // advance model
        if (phase == c_free) begin
            if (any) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                if (if_pend && dm_pend) rr_last_dm = win_dm;
`endif
                own_dm = win_dm;
                if (win_dm) begin
                    g_addr = dm_a; g_we = dm_we_m; g_wdata = dm_wd; g_be = dm_b;
                end else begin
                    g_addr = if_a; g_we = 1'b0; g_wdata = '0; g_be = 4'hF;
                end
                phase = c_req;
                gwait = (force_gw >= 0) ? force_gw : int'($urandom_range(2));
                rwait = (force_rw >= 0) ? force_rw : int'($urandom_range(2));
            end
        end else if (phase == c_req) begin
            if (gwait > 0) gwait--;
            else if (rwait == 0) phase = c_free;
            else begin phase = c_rsp; rwait--; end
        end else begin
            if (rwait == 0) phase = c_free;
            else rwait--;
        end
        if (comp) begin
            if (own_dm) dm_pend = 1'b0;
            else if (!discard) if_pend = 1'b0;
            discard = 1'b0;
        end
        if (real_fl) begin
            discard = 1'b1;
            if_pend = 1'b0;     // flushed fetch is abandoned by the requester
        end
        if (rand_en) begin
            if (!if_pend && $urandom_range(2) == 0) begin
                if_pend = 1'b1; if_a = $urandom & 32'hFFFF_FFFC;
            end
            if (!dm_pend && $urandom_range(2) == 0) begin
                dm_pend = 1'b1; dm_we_m = ($urandom_range(1) == 1);
                dm_a = $urandom; dm_wd = $urandom; dm_b = 4'($urandom);
            end
        end

        @(posedge clk); #1;
        cyc++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        i_rst = 1'b1;
        i_if_req = 0; i_if_addr = 0; i_if_flush = 0;
        i_dm_req = 0; i_dm_we = 0; i_dm_addr = 0; i_dm_wdata = 0; i_dm_be = 0;
        i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rdata = 0;
        rand_en = 0; force_flush = 0; force_spur = 0; rd_force = 0; rd_val = 0;
        force_gw = -1; force_rw = -1; cyc = 0;
        if_a = 0; dm_a = 0; dm_wd = 0; dm_b = 0; dm_we_m = 0;
        g_addr = 0; g_wdata = 0; g_we = 0; g_be = 0;
        model_reset();
        clear_obs();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        i_rst = 1'b0;
        check_all_zero("reset");
        @(posedge clk); #1;

        // lone fetch: accept next cycle, response two cycles after accept
        clear_obs();
        force_gw = 0; force_rw = 2; rd_force = 1; rd_val = 32'h00A0_0093;
        if_pend = 1; if_a = 32'h100;
        repeat (6) cycle();
        chk("fetch_rv_count",  64'(cnt_if_rv),     64'd1);
        chk("fetch_rdata",     64'(last_if_rdata), 64'h00A0_0093);
        chk("fetch_req_count", 64'(cnt_mem_req),   64'd1);
        rd_force = 0;

        // simultaneous fetch and data read
        clear_obs();
        force_gw = 1; force_rw = 1;
        if_pend = 1; if_a = 32'h104;
        dm_pend = 1; dm_we_m = 0; dm_a = 32'h2000; dm_wd = 0; dm_b = 4'hF;
        repeat (12) cycle();
        chk("both_first_gnt_dm", 64'(first_gnt), 64'd1);
        chk("both_if_gnt_delay", 64'(t_if_gnt - t_dm_rv), 64'd1);
        chk("both_if_rv_count",  64'(cnt_if_rv), 64'd1);
        chk("both_dm_rv_count",  64'(cnt_dm_rv), 64'd1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        clear_obs();
        if_pend = 1; if_a = 32'h110;
        dm_pend = 1; dm_we_m = 0; dm_a = 32'h2010; dm_b = 4'hF;
        repeat (12) cycle();
        chk("rr_second_first_gnt_if", 64'(first_gnt), 64'd0);
`endif

        // data write accepted and answered in the same cycle
        clear_obs();
        force_gw = 0; force_rw = 0;
        dm_pend = 1; dm_we_m = 1; dm_a = 32'h2004; dm_wd = 32'hDEAD_BEEF; dm_b = 4'h3;
        repeat (4) cycle();
        chk("wr_req_count", 64'(cnt_mem_req), 64'd1);
        chk("wr_rv_count",  64'(cnt_dm_rv),   64'd1);

        // fetch flushed while waiting for its response
        clear_obs();
        force_gw = 0; force_rw = 3; force_flush = 1;
        if_pend = 1; if_a = 32'h108;
        repeat (7) cycle();
        force_flush = 0;
        chk("flush_if_rv_count", 64'(cnt_if_rv), 64'd0);
        dm_pend = 1; dm_we_m = 0; dm_a = 32'h2008; dm_b = 4'hF;
        force_gw = 0; force_rw = 0;
        repeat (4) cycle();
        chk("flush_then_dm_rv", 64'(cnt_dm_rv), 64'd1);

        // stray memory handshake while idle, with and without a request
        clear_obs();
        force_gw = -1; force_rw = -1; force_spur = 1;
        repeat (2) cycle();
        chk("spur_rv_count",  64'(cnt_if_rv + cnt_dm_rv), 64'd0);
        chk("spur_req_count", 64'(cnt_mem_req), 64'd0);
        if_pend = 1; if_a = 32'h200;
        cycle();
        force_spur = 0;
        repeat (8) cycle();
        chk("spur_then_fetch_rv", 64'(cnt_if_rv), 64'd1);

        // randomized traffic
        rand_en = 1;
        repeat (400) cycle();
        rand_en = 0;
        for (int k = 0; k < 80; k++) begin
            if (phase == c_free && !if_pend && !dm_pend) break;
            cycle();
        end
        chk("drain_idle", 64'(phase == c_free && !if_pend && !dm_pend), 64'd1);

        // reset while waiting for a response, then a late response
        clear_obs();
        force_gw = 0; force_rw = 5;
        if_pend = 1; if_a = 32'h10C;
        repeat (3) cycle();
        i_rst = 1; i_if_req = 0; i_dm_req = 0; i_if_flush = 0;
        i_mem_gnt = 0; i_mem_rvalid = 0;
        @(posedge clk); #1;
        i_rst = 0; i_mem_rvalid = 1; i_mem_rdata = 32'h1234_5678;
        check_all_zero("rst_mid");
        @(posedge clk); #1;
        check_all_zero("rst_late_rsp");
        i_mem_rvalid = 0;
        model_reset();
        @(posedge clk); #1;
        force_gw = -1; force_rw = -1;
        dm_pend = 1; dm_we_m = 0; dm_a = 32'h3000; dm_b = 4'hF;
        repeat (8) cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
